// File: rtl/tpu_host_pkg.sv
// Shared types and MMIO map for the TPU host-side job controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_host_pkg;

   // Job sequencer states, in the order a job walks through them.
   typedef enum logic [3:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      TRIGGER,
      WAIT,
      RD_REQ,
      RD_CAP,
      OUT,
      DONE
   } state_t;

   // MMIO map: A rows, B rows, C words, MatMul trigger register.
   localparam logic [15:0] A_BASE    = 16'h0100;
   localparam logic [15:0] B_BASE    = 16'h0200;
   localparam logic [15:0] C_BASE    = 16'h0300;
   localparam logic [15:0] TRIG_ADDR = 16'h0400;

   // Consecutive words sit 8 bytes apart.
   localparam int unsigned WORD_SHIFT = 3;

endpackage

// File: rtl/tpu_host_ctrl.sv
// Host job controller: streams A then B rows into TPU MMIO, triggers MatMul, reads C back.
// Latency: MMIO write same cycle as input handshake; each C word 2 cycles after its read issue.
// Backpressure: in_ready only while loading; a pending C word blocks the next read until out_ready.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   start / busy / done      job kick, job-in-progress, one-cycle completion pulse
//   in_valid/in_ready/in_data    A-then-B row stream (DIM rows each)
//   out_valid/out_ready/out_data C word stream (2*DIM words)
//   tpu_r_w/tpu_addr/tpu_wdata/tpu_rdata  MMIO bus; rdata valid one cycle after a read address
module tpu_host_ctrl
   import tpu_host_pkg::*;
#(
   parameter int DIM           = 8,
   parameter int ADDRW         = 16,
   parameter int DATAW         = 64,
   parameter int MATMUL_CYCLES = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             tpu_r_w,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_wdata,
   input  logic [DATAW-1:0] tpu_rdata
);

   // Each counter is just wide enough for its terminal value.
   localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int JW = $clog2(2 * DIM);
   localparam int WW = (MATMUL_CYCLES > 1) ? $clog2(MATMUL_CYCLES) : 1;

   localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);
   localparam logic [JW-1:0] J_LAST = JW'(2 * DIM - 1);
   localparam logic [WW-1:0] W_LAST = WW'(MATMUL_CYCLES - 1);

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;         // A/B row index within the current phase
   logic [WW-1:0]    w_q, w_d;         // MatMul wait cycle count
   logic [JW-1:0]    j_q, j_d;         // C word index
   logic [DATAW-1:0] out_data_q, out_data_d;

   function automatic logic [ADDRW-1:0] word_addr(input logic [15:0] base,
                                                   input logic [JW-1:0] idx);
      return ADDRW'(base) + (ADDRW'(idx) << WORD_SHIFT);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         k_q        <= '0;
         w_q        <= '0;
         j_q        <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         w_q        <= w_d;
         j_q        <= j_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      w_d        = w_q;
      j_d        = j_q;
      out_data_d = out_data_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      tpu_r_w    = 1'b0;
      tpu_addr   = '0;
      tpu_wdata  = '0;

      unique case (state_q)
         IDLE: begin
            k_d = '0;
            w_d = '0;
            j_d = '0;
            if (start) state_d = LOAD_A;
         end
         LOAD_A, LOAD_B: begin
            in_ready = 1'b1;
            // The MMIO write rides on the same cycle as the input handshake.
            if (in_valid) begin
               tpu_r_w   = 1'b1;
               tpu_wdata = in_data;
               tpu_addr  = word_addr((state_q == LOAD_A) ? A_BASE : B_BASE, JW'(k_q));
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  state_d = (state_q == LOAD_A) ? LOAD_B : TRIGGER;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         TRIGGER: begin
            tpu_r_w  = 1'b1;
            tpu_addr = ADDRW'(TRIG_ADDR);
            w_d      = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            if (w_q == W_LAST) begin
               w_d     = '0;
               j_d     = '0;
               state_d = RD_REQ;
            end else begin
               w_d = w_q + 1'b1;
            end
         end
         RD_REQ: begin
            tpu_addr = word_addr(C_BASE, j_q);
            state_d  = RD_CAP;
         end
         RD_CAP: begin
            // Read data lands one cycle after the address.
            out_data_d = tpu_rdata;
            state_d    = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (j_q == J_LAST) begin
                  j_d     = '0;
                  state_d = DONE;
               end else begin
                  j_d     = j_q + 1'b1;
                  state_d = RD_REQ;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign out_data = out_data_q;

endmodule
